// File: rtl/data_mem_controller_pkg.sv
// Shared definitions for the MEM-stage data memory controller:
// FSM state encoding, fault codes, RV32 load/store funct3 values and a
// natural-alignment helper.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISALIGN = 2'd1;
    localparam logic [1:0] FC_CONFLICT = 2'd2;
    localparam logic [1:0] FC_TIMEOUT  = 2'd3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size comes from funct3[1:0]: halfwords need bit 0 clear,
    // words need both low address bits clear, bytes are always aligned.
    function automatic logic access_misaligned(input logic [2:0] f3,
                                               input logic [1:0] addr_lo);
        case (f3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return (addr_lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_controller_align_check.sv
// Combinational legality check for one load/store request: flags a
// simultaneous read+write request, funct3 values that are not a valid
// load/store, and addresses not naturally aligned to the access size.
module mem_align_check
    import mem_ctrl_pkg::*;
(
    input  logic [1:0] addr_lo_i,
    input  logic [2:0] func3_i,
    input  logic       rd_en_i,
    input  logic       wr_en_i,
    output logic       legal_o,
    output logic [1:0] code_o
);

    // Classify the request; conflict takes precedence over alignment.
    always_comb begin
        code_o  = FC_NONE;
        legal_o = 1'b1;
        if (rd_en_i && wr_en_i) begin
            code_o = FC_CONFLICT;
        end else if (rd_en_i) begin
            case (func3_i)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: begin
                    if (access_misaligned(func3_i, addr_lo_i)) code_o = FC_MISALIGN;
                end
                default: code_o = FC_MISALIGN;
            endcase
        end else if (wr_en_i) begin
            case (func3_i)
                F3_B, F3_H, F3_W: begin
                    if (access_misaligned(func3_i, addr_lo_i)) code_o = FC_MISALIGN;
                end
                default: code_o = FC_MISALIGN;
            endcase
        end
        legal_o = (code_o == FC_NONE);
    end

endmodule

// File: rtl/data_mem_controller.sv
// MEM-stage load/store initiator. Takes one request from EX/MEM, holds the
// memory request stable until busywait completes (or a timeout aborts it),
// stalls the pipeline meanwhile and returns load data with a valid pulse.
// Illegal requests never reach memory; they produce a one-cycle Fault.
// TIMEOUT_CYCLES must be >= 2 and representable in CNT_W bits.
module data_mem_controller
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Mem_Read_En,
    input  logic        Mem_Write_En,
    input  logic [31:0] Addr,
    input  logic [31:0] Store_data,
    input  logic [2:0]  Func3_in,
    output logic        Stall,
    output logic [31:0] Load_data,
    output logic        Load_valid,
    output logic        Fault,
    output logic [1:0]  Fault_code,
    output logic        Read,
    output logic        Write,
    output logic [31:0] Address,
    output logic [31:0] Write_data,
    output logic [2:0]  Func3,
    input  logic [31:0] Read_data,
    input  logic        busywait
);

    // Abort on the cycle whose increment would bring the count to
    // TIMEOUT_CYCLES, so ACCESS lasts at most TIMEOUT_CYCLES cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic              lv_q, lv_d;
    logic              fault_q, fault_d;
    logic [1:0]        fc_q, fc_d;
    logic [31:0]       ld_q, ld_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wd_q, wd_d;
    logic [2:0]        f3_q, f3_d;

    logic              req;
    logic              legal;
    logic [1:0]        chk_code;
    logic              stall;

    assign req = Mem_Read_En | Mem_Write_En;

    mem_align_check u_align_check (
        .addr_lo_i (Addr[1:0]),
        .func3_i   (Func3_in),
        .rd_en_i   (Mem_Read_En),
        .wr_en_i   (Mem_Write_En),
        .legal_o   (legal),
        .code_o    (chk_code)
    );

    // Next-state and output decode; registers hold unless a state acts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        read_d  = read_q;
        write_d = write_q;
        lv_d    = 1'b0;
        fault_d = 1'b0;
        fc_d    = fc_q;
        ld_d    = ld_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        f3_d    = f3_q;
        stall   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                stall = req;
                if (req) begin
                    if (legal) begin
                        addr_d  = Addr;
                        wd_d    = Store_data;
                        f3_d    = Func3_in;
                        read_d  = Mem_Read_En;
                        write_d = Mem_Write_En;
                        cnt_d   = '0;
                        state_d = ST_ACCESS;
                    end else begin
                        fault_d = 1'b1;
                        fc_d    = chk_code;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_ACCESS: begin
                stall = 1'b1;
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                // busywait may still be low in the first ACCESS cycle, so a
                // completion is only trusted once the counter has moved.
                if (!busywait && (cnt_q != '0)) begin
                    if (read_q) begin
                        ld_d = Read_data;
                        lv_d = 1'b1;
                    end
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = ST_DONE;
                end else if (busywait && (cnt_q >= CNT_LAST)) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    fault_d = 1'b1;
                    fc_d    = FC_TIMEOUT;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset drops the memory request at once.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            lv_q    <= 1'b0;
            fault_q <= 1'b0;
            fc_q    <= FC_NONE;
            ld_q    <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            f3_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            read_q  <= read_d;
            write_q <= write_d;
            lv_q    <= lv_d;
            fault_q <= fault_d;
            fc_q    <= fc_d;
            ld_q    <= ld_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            f3_q    <= f3_d;
        end
    end

    assign Stall      = stall;
    assign Load_data  = ld_q;
    assign Load_valid = lv_q;
    assign Fault      = fault_q;
    assign Fault_code = fc_q;
    assign Read       = read_q;
    assign Write      = write_q;
    assign Address    = addr_q;
    assign Write_data = wd_q;
    assign Func3      = f3_q;

endmodule

// File: tb/tb_data_mem_controller.sv
// Bench for data_mem_controller: a busywait memory model, directed requests
// with hand-computed cycle counts, and a scoreboard that matches every
// Load_valid / Fault pulse against the response queued at issue time.
module tb_data_mem_controller;
    import mem_ctrl_pkg::*;

    localparam int TO = 8;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Mem_Read_En, Mem_Write_En;
    logic [31:0] Addr, Store_data;
    logic [2:0]  Func3_in;
    logic        Stall;
    logic [31:0] Load_data;
    logic        Load_valid, Fault;
    logic [1:0]  Fault_code;
    logic        Read, Write;
    logic [31:0] Address, Write_data;
    logic [2:0]  Func3;
    logic [31:0] Read_data;
    logic        busywait;

    data_mem_controller #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
        .Clock(Clock), .Reset(Reset),
        .Mem_Read_En(Mem_Read_En), .Mem_Write_En(Mem_Write_En),
        .Addr(Addr), .Store_data(Store_data), .Func3_in(Func3_in),
        .Stall(Stall), .Load_data(Load_data), .Load_valid(Load_valid),
        .Fault(Fault), .Fault_code(Fault_code),
        .Read(Read), .Write(Write), .Address(Address),
        .Write_data(Write_data), .Func3(Func3),
        .Read_data(Read_data), .busywait(busywait)
    );

    always #5 Clock = ~Clock;

    // Memory model: busywait rises with Read/Write and stays high for busy_n cycles.
    int busy_n  = 0;
    int elapsed = 0;
    assign busywait = (Read || Write) && (elapsed < busy_n);
    always @(posedge Clock) elapsed <= (Read || Write) ? elapsed + 1 : 0;

    typedef struct packed {
        logic        is_fault;
        logic [1:0]  code;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every response pulse must match the queue head.
    always @(negedge Clock) begin
        if (!Reset && (Load_valid || Fault)) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: Load_valid=%0b Fault=%0b with empty queue", Load_valid, Fault);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_fault_pulse", Fault, e.is_fault);
                check("sb_lv_pulse", Load_valid, !e.is_fault);
                if (e.is_fault) check("sb_fault_code", Fault_code, e.code);
                else            check("sb_load_data", Load_data, e.data);
            end
        end
    end

    // One request from IDLE through DONE; fcode is the expected outcome
    // (FC_NONE for a completed access).
    task automatic run_req(input string nm, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] sd,
                           input logic [2:0] f3, input int bn,
                           input logic [31:0] rdata, input logic [1:0] fcode);
        int   exp_rw, exp_stall;
        int   rd_cnt = 0, wr_cnt = 0, st_cnt = 0;
        bit   stable = 1, both = 0, done = 0;
        logic lv_done = 0, f_done = 0;
        logic [1:0] fc_done = 0;
        exp_t e;

        if (fcode == FC_MISALIGN || fcode == FC_CONFLICT) exp_rw = 0;
        else if (fcode == FC_TIMEOUT)                      exp_rw = TO;
        else                                               exp_rw = bn + 1;
        exp_stall = exp_rw + 1;

        e.is_fault = (fcode != FC_NONE);
        e.code     = fcode;
        e.data     = rdata;
        if (fcode != FC_NONE || rd) exp_q.push_back(e);

        @(posedge Clock); #1;
        busy_n       = bn;
        Read_data    = rdata;
        Mem_Read_En  = rd;
        Mem_Write_En = wr;
        Addr         = a;
        Store_data   = sd;
        Func3_in     = f3;
        @(negedge Clock);
        if (Stall) st_cnt++;
        @(posedge Clock); #1;
        Mem_Read_En  = 1'b0;
        Mem_Write_En = 1'b0;
        Addr         = 32'hFFFF_FFFF;
        Store_data   = ~sd;
        Func3_in     = 3'b111;
        for (int k = 1; k < 40 && !done; k++) begin
            @(negedge Clock);
            if (Read && Write) both = 1;
            if (Read)  rd_cnt++;
            if (Write) wr_cnt++;
            if ((Read || Write) && (Address !== a || Write_data !== sd || Func3 !== f3)) stable = 0;
            if (Stall) st_cnt++;
            else begin
                done    = 1;
                lv_done = Load_valid;
                f_done  = Fault;
                fc_done = Fault_code;
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_bound: Stall never released within 40 cycles", nm);
        end
        check({nm, "_read_cycles"},  rd_cnt, (rd && !wr) ? exp_rw : 0);
        check({nm, "_write_cycles"}, wr_cnt, (wr && !rd) ? exp_rw : 0);
        check({nm, "_stall_cycles"}, st_cnt, exp_stall);
        check({nm, "_rw_exclusive"}, both, 0);
        check({nm, "_req_stable"},   stable, 1);
        check({nm, "_lv_in_done"},   lv_done, (fcode == FC_NONE) && rd);
        check({nm, "_fault_in_done"}, f_done, fcode != FC_NONE);
        if (fcode != FC_NONE) check({nm, "_code_in_done"}, fc_done, fcode);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        Mem_Read_En = 1'b0; Mem_Write_En = 1'b0;
        Addr = '0; Store_data = '0; Func3_in = '0; Read_data = '0;
        repeat (3) @(negedge Clock);
        check("rst_read",       Read, 0);
        check("rst_write",      Write, 0);
        check("rst_stall",      Stall, 0);
        check("rst_load_valid", Load_valid, 0);
        check("rst_fault",      Fault, 0);
        check("rst_fault_code", Fault_code, 0);
        check("rst_load_data",  Load_data, 0);
        check("rst_address",    Address, 0);
        check("rst_write_data", Write_data, 0);
        check("rst_func3",      Func3, 0);
        @(posedge Clock); #1;
        Reset = 1'b0;

        run_req("lw_basic",  1, 0, 32'h0000_0010, 32'h0,         F3_W,  1, 32'hDEAD_BEEF, FC_NONE);
        run_req("sw_busy4",  0, 1, 32'h0000_0020, 32'h1234_5678, F3_W,  4, 32'h0,         FC_NONE);
        run_req("lh_misal",  1, 0, 32'h0000_0003, 32'h0,         F3_H,  1, 32'h0,         FC_MISALIGN);
        run_req("conflict",  1, 1, 32'h0000_0000, 32'h0,         F3_W,  1, 32'h0,         FC_CONFLICT);
        run_req("lb_odd",    1, 0, 32'h0000_0003, 32'h0,         F3_B,  2, 32'hFFFF_FF80, FC_NONE);
        @(negedge Clock);
        check("fault_code_hold", Fault_code, FC_CONFLICT);
        run_req("ld_f3_011", 1, 0, 32'h0000_0000, 32'h0,         3'b011, 1, 32'h0,        FC_MISALIGN);
        run_req("st_f3_100", 0, 1, 32'h0000_0000, 32'hAAAA_5555, 3'b100, 1, 32'h0,        FC_MISALIGN);
        run_req("sh_even",   0, 1, 32'h0000_0102, 32'h0000_BEEF, F3_H,  1, 32'h0,         FC_NONE);
        run_req("lw_misal",  1, 0, 32'h0000_0102, 32'h0,         F3_W,  1, 32'h0,         FC_MISALIGN);
        run_req("lhu_even",  1, 0, 32'h0000_0006, 32'h0,         F3_HU, 3, 32'h0000_8001, FC_NONE);
        run_req("timeout",   1, 0, 32'h0000_0044, 32'h0,         F3_W,  1000, 32'h0,      FC_TIMEOUT);

        // Reset in the second ACCESS cycle of a load.
        @(posedge Clock); #1;
        busy_n = 5; Read_data = 32'h0BAD_0BAD;
        Mem_Read_En = 1'b1; Addr = 32'h0000_0030; Func3_in = F3_W;
        @(posedge Clock); #1;
        Mem_Read_En = 1'b0;
        @(posedge Clock); #1;
        check("rst_mid_read_before", Read, 1);
        Reset = 1'b1;
        #1;
        check("rst_mid_read_drop", Read, 0);
        check("rst_mid_write",     Write, 0);
        check("rst_mid_stall",     Stall, 0);
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            check("rst_after_quiet", {Load_valid, Fault, Stall, Read}, 0);
        end
        check("rst_after_fault_code", Fault_code, 0);
        run_req("lw_after_rst", 1, 0, 32'h0000_0040, 32'h0, F3_W, 3, 32'hCAFE_F00D, FC_NONE);

        repeat (3) @(negedge Clock);
        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_controller.md
# data_mem_controller

MEM-stage load/store initiator for the RV32IM pipeline: accepts one load or store per request from the EX/MEM register and drives the data memory's Read/Write/Address/Func3 request port. It holds the request until the memory's busywait handshake completes, stalls the pipeline meanwhile, and returns load data with a valid pulse. It rejects misaligned, conflicting and timed-out accesses with a fault code.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles in ACCESS before abort; must be at least 2.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- Mem_Read_En  in  1  pipeline load request.
- Mem_Write_En  in  1  pipeline store request.
- Addr  in  32  byte address.
- Store_data  in  32  store operand, unaligned; the memory selects lanes.
- Func3_in  in  3  RV32 load/store funct3.
- Stall  out  1  freeze IF..MEM while high.
- Load_data  out  32  sign- or zero-extended load result.
- Load_valid  out  1  one-cycle pulse, Load_data valid.
- Fault  out  1  one-cycle pulse.
- Fault_code  out  2  0 none, 1 misaligned/illegal funct3, 2 read+write conflict, 3 timeout.
- Read  out  1  memory read request.
- Write  out  1  memory write request.
- Address  out  32  registered Addr.
- Write_data  out  32  registered Store_data.
- Func3  out  3  registered Func3_in.
- Read_data  in  32  memory read result.
- busywait  in  1  memory busy; rises combinationally with Read/Write, falls at a clock edge when the access is done.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - A request is present when Mem_Read_En or Mem_Write_En is high.
  - Stall = request present (combinational).
  - Legality check:
    - Both enables high: conflict, code 2.
    - LH/LHU/SH with Addr[0]=1: code 1.
    - LW/SW with Addr[1:0]≠0: code 1.
    - Load funct3 of 011, 110 or 111: code 1.
    - Store funct3 above 010: code 1.
  - Legal request: at the next edge, register Address, Write_data and Func3; assert Read or Write; clear the counter; go to ACCESS.
  - Illegal request: at the next edge, pulse Fault with Fault_code; no memory request is issued; go to DONE.
- **ACCESS**
  - Read or Write stays high; all memory-side outputs stay stable; Stall=1; the counter increments each cycle.
  - Exit when busywait is sampled 0 and the counter is at least 1.
    - Load: capture Read_data into Load_data, pulse Load_valid.
    - Store: no Load_valid.
    - Drop Read/Write; go to DONE.
  - Timeout: when the counter reaches TIMEOUT_CYCLES with busywait still 1, drop Read/Write, pulse Fault with code 3, go to DONE.
- **DONE**
  - Stall=0 for one cycle so the pipeline advances; go to IDLE.
  - A new request is not accepted in DONE; it is seen in IDLE on the following cycle.
- Load_data holds its last value until the next load completes.
- Fault_code holds until the next fault or reset.

## Timing
- Reset values: Read=0, Write=0, Stall=0, Load_valid=0, Fault=0, Fault_code=0, Load_data=0, Address=0, Write_data=0, Func3=0, state IDLE, counter 0.
- Reset mid-access: Read and Write drop asynchronously and the state returns to IDLE; no Load_valid or Fault is produced.
- Minimum legal access: request in IDLE at cycle 0.
  - Cycle 1: ACCESS, Read/Write high.
  - Cycle 2: busywait sampled 0 at earliest.
  - Cycle 3: DONE, Load_valid high.
  - Stall is high for cycles 0–2 and low in cycle 3.
- Fault path: fault at cycle 0, Fault pulse in cycle 1 (DONE), Stall low in cycle 1.
- Read and Write are never high together, and never change while busywait=1, except on timeout or reset.
- Counter saturates and does not wrap; CNT_W must cover TIMEOUT_CYCLES.

## Structure
- Package mem_ctrl_pkg holds:
  - State encoding (IDLE=0, ACCESS=1, DONE=2).
  - Fault code constants FC_NONE, FC_MISALIGN, FC_CONFLICT, FC_TIMEOUT.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
- Sub-module mem_align_check: combinational legality check taking Addr[1:0], Func3_in, Mem_Read_En and Mem_Write_En; outputs legal and a 2-bit code.

## Test plan
- LW at 0x0000_0010, memory returns 0xDEAD_BEEF after 1 busy cycle → Read high in cycles 1–2, Load_valid in cycle 3 with Load_data=0xDEAD_BEEF, Stall high in cycles 0–2.
- SW of 0x1234_5678 to 0x20, busywait held 4 cycles → Write stable for 5 cycles, no Load_valid, Stall releases in DONE.
- LH at 0x0000_0003 → Fault=1 with code 1 one cycle later, Read never asserted, Stall high 1 cycle.
- Mem_Read_En and Mem_Write_En both high → Fault code 2, Read=Write=0 throughout.
- busywait stuck at 1 with TIMEOUT_CYCLES=8 → Read drops after 8 ACCESS cycles, Fault code 3, then IDLE.
- Reset asserted in the 2nd ACCESS cycle → Read=0 immediately, state IDLE, Stall=0, no Load_valid; the next LW completes normally.
